dmem_responder: RTL

//  Responder (memory side) for the datapath's data-memory interface: serves memRead/memWrite

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the datapath (master) and the memory responder (slave).
interface dmem_responder_if #(
   parameter int SIZE = 64
);
   logic            memRead;
   logic            memWrite;
   logic [SIZE-1:0] readAddress;
   logic [SIZE-1:0] writeAddress;
   logic [SIZE-1:0] writeData;
   logic [SIZE-1:0] readDataMem;
   logic            ready;
   logic            err;

   modport master (
      output memRead, memWrite, readAddress, writeAddress, writeData,
      input  readDataMem, ready, err
   );

   modport slave (
      input  memRead, memWrite, readAddress, writeAddress, writeData,
      output readDataMem, ready, err
   );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: IDLE -> BUSY (LATENCY waits) -> DONE with a one-cycle ready pulse.
// Optional address checking is enabled by defining DMEM_BOUNDS_CHECK_EN; otherwise err is tied low.
module dmem_responder #(
   parameter int SIZE    = 64,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [3:0]      cnt_reg, cnt_next;
   logic            capture;
   logic            access;

   logic            op_write_reg;
   logic [AW-1:0]   idx_reg;
   logic [SIZE-1:0] data_reg;
   logic [SIZE-1:0] read_data_reg;
   logic            wr_en;

   logic [SIZE-1:0] mem [DEPTH];

   // A write wins when both strobes are high, so the write address is the one captured.
   logic [SIZE-1:0] req_addr;
   logic [AW-1:0]   req_idx;
   assign req_addr = bus.memWrite ? bus.writeAddress : bus.readAddress;
   assign req_idx  = req_addr[3 +: AW];

`ifdef DMEM_BOUNDS_CHECK_EN
   logic req_bad;
   logic bad_reg;
   logic err_reg;

   generate
      if (SIZE > 3 + AW) begin : g_hi_check
         assign req_bad = (req_addr[2:0] != 3'd0) || (req_addr[SIZE-1:3+AW] != '0);
      end else begin : g_no_hi_check
         assign req_bad = (req_addr[2:0] != 3'd0);
      end
   endgenerate
`else
   generate
      if (SIZE > 3 + AW) begin : g_wrap
         logic unused_addr_bits;
         assign unused_addr_bits = ^{req_addr[SIZE-1:3+AW], req_addr[2:0]};
      end else begin : g_no_wrap
         logic unused_addr_bits;
         assign unused_addr_bits = ^req_addr[2:0];
      end
   endgenerate
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      access     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.memRead || bus.memWrite) begin
               capture    = 1'b1;
               cnt_next   = CNT_INIT;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (cnt_reg == 4'd0) begin
               access     = 1'b1;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_write_reg  <= 1'b0;
         idx_reg       <= '0;
         data_reg      <= '0;
         read_data_reg <= '0;
`ifdef DMEM_BOUNDS_CHECK_EN
         bad_reg       <= 1'b0;
         err_reg       <= 1'b0;
`endif
      end else begin
         if (capture) begin
            op_write_reg <= bus.memWrite;
            idx_reg      <= req_idx;
            data_reg     <= bus.writeData;
`ifdef DMEM_BOUNDS_CHECK_EN
            bad_reg      <= req_bad;
`endif
         end
`ifdef DMEM_BOUNDS_CHECK_EN
         if (access) begin
            err_reg <= bad_reg;
         end
         if (access && !op_write_reg) begin
            read_data_reg <= bad_reg ? '0 : mem[idx_reg];
         end
`else
         if (access && !op_write_reg) begin
            read_data_reg <= mem[idx_reg];
         end
`endif
      end
   end

   // Reset on the completion edge must abort the write, hence the explicit rst gate.
`ifdef DMEM_BOUNDS_CHECK_EN
   assign wr_en = access && op_write_reg && !bad_reg && !rst;
`else
   assign wr_en = access && op_write_reg && !rst;
`endif

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx_reg] <= data_reg;
      end
   end

   assign bus.readDataMem = read_data_reg;
   assign bus.ready       = (state_reg == DONE);
`ifdef DMEM_BOUNDS_CHECK_EN
   assign bus.err         = err_reg;
`else
   assign bus.err         = 1'b0;
`endif

endmodule
